sha256_w_sched_ctrl: RTL and testbench

//  Sequencer for the SHA-256 message schedule. Accepts one 512-bit block, then streams W[0..ROUNDS-1]
//  one word per handshake to the compression core, holding a 16-word sliding window and generating
//  W[t>=16] with the standard sigma0/sigma1 recurrence.

---
 rtl/sha256_w_sched_ctrl.sv | 134 +++++++++++++
 tb/tb_sha256_w_sched_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sha256_w_sched_ctrl.sv
// sha256_w_sched_ctrl: SHA-256 message schedule sequencer.
// Takes one 512-bit block, then streams W[0..ROUNDS-1] one word per w handshake,
// generating W[t>=16] from a 16-word sliding window.
// Optional feature macro: SHA256_WSCHED_STALL_CNT_EN adds stall_cnt[15:0], a saturating
// count of cycles with w_valid && !w_ready, cleared on reset and on block accept.
//
// state  | meaning
// IDLE   | waiting for a block, in_ready=1, w_valid=0
// STREAM | presenting window[0] as W[t], shifting on each w handshake
module sha256_w_sched_ctrl #(
    parameter int ROUNDS = 64,
    parameter int IDX_W  = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [511:0]     block_in,
    input  logic             abort,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [31:0]      w_out,
    output logic [IDX_W-1:0] w_idx,
    output logic             w_last,
    output logic             done,
    output logic             busy
`ifdef SHA256_WSCHED_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] T_LAST = IDX_W'(ROUNDS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      window [16];
    logic [IDX_W-1:0] t;
    logic             done_r;
    logic             accept;
    logic             shift;
    logic             final_hs;
    logic [31:0]      w_new;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Next schedule word from the current window (carries past bit 31 drop naturally).
    always_comb begin
        w_new = sig0(window[1]) + window[9] + sig1(window[14]) + window[0];
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode; abort wins over both handshakes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        shift     = 1'b0;
        final_hs  = 1'b0;
        case (state)
            IDLE: begin
                if (!abort && in_valid) begin
                    accept    = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (w_ready) begin
                    shift = 1'b1;
                    if (t == T_LAST) begin
                        final_hs  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Window, word index and done pulse; t returns to 0 after the last word so it never wraps.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            t      <= '0;
            done_r <= 1'b0;
            for (int i = 0; i < 16; i++) window[i] <= '0;
        end else begin
            done_r <= final_hs;
            if (accept) begin
                t <= '0;
                for (int i = 0; i < 16; i++) window[i] <= block_in[511 - 32*i -: 32];
            end else if (abort) begin
                t <= '0;
            end else if (shift) begin
                for (int i = 0; i < 15; i++) window[i] <= window[i+1];
                window[15] <= w_new;
                t <= final_hs ? '0 : t + IDX_W'(1);
            end
        end
    end

`ifdef SHA256_WSCHED_STALL_CNT_EN
    // Saturating stall counter; holds its value through IDLE until the next accept.
    always_ff @(posedge CLK) begin
        if (!RST || accept)                              stall_cnt <= '0;
        else if (w_valid && !w_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
    end
`endif

    assign busy     = (state == STREAM);
    assign in_ready = (state == IDLE);
    assign w_valid  = busy;
    assign w_out    = window[0];
    assign w_idx    = t;
    assign w_last   = busy && (t == T_LAST);
    assign done     = done_r;

endmodule

// File: tb/tb_sha256_w_sched_ctrl.sv
// Self-checking bench for sha256_w_sched_ctrl: reference schedule from the textbook
// W[t] recurrence, random w_ready stalls, abort, back-to-back and mid-block reset.
module tb_sha256_w_sched_ctrl;

    logic         CLK = 1'b0;
    logic         RST;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] block_in;
    logic         abort;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         w_last;
    logic         done;
    logic         busy;
`ifdef SHA256_WSCHED_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] wexp [64];

    localparam logic [511:0] ABC = {32'h61626380, 448'd0, 32'h00000018};

    sha256_w_sched_ctrl #(.ROUNDS(64), .IDX_W(6)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .block_in (block_in),
        .abort    (abort),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_out    (w_out),
        .w_idx    (w_idx),
        .w_last   (w_last),
        .done     (done),
        .busy     (busy)
`ifdef SHA256_WSCHED_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Plain textbook message schedule over a 64-entry array.
    task automatic ref_calc(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) wexp[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            logic [31:0] s0, s1;
            s0 = rotr(wexp[i-15], 7) ^ rotr(wexp[i-15], 18) ^ (wexp[i-15] >> 3);
            s1 = rotr(wexp[i-2], 17) ^ rotr(wexp[i-2], 19) ^ (wexp[i-2] >> 10);
            wexp[i] = s1 + wexp[i-7] + s0 + wexp[i-16];
        end
    endtask

    // Run one block. rdy_pct: chance of w_ready per cycle; abort_at/rst_at: idx to
    // interrupt (-1 none); hold_next keeps in_valid high with nblk so it is taken in
    // the done cycle; pre_accepted skips the accept step (block already taken).
    task automatic run_block(input string tag, input logic [511:0] blk, input int rdy_pct,
                             input int abort_at, input int rst_at, input bit hold_next,
                             input logic [511:0] nblk, input bit pre_accepted);
        int idx = 0;
        int cyc = 0;
        int hs = 0;
        int stalls = 0;
        bit timed_out = 0;
        bit rdy;
        ref_calc(blk);
        if (!pre_accepted) begin
            @(negedge CLK);
            chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            block_in = blk;
            @(posedge CLK);
        end
        forever begin
            @(negedge CLK);
            cyc++;
            abort = 1'b0;
            in_valid = hold_next;
            block_in = hold_next ? nblk : blk;
            if (cyc > 400) begin
                chk({tag, "_timeout"}, 64'd0, 64'd1);
                timed_out = 1;
                break;
            end
            chk({tag, "_w_valid"}, 64'(w_valid), 64'd1);
            chk({tag, "_w_idx"}, 64'(w_idx), 64'(idx));
            chk({tag, "_w_out"}, 64'(w_out), 64'(wexp[idx]));
            chk({tag, "_w_last"}, 64'(w_last), 64'(idx == 63));
            chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
            chk({tag, "_done_busy"}, 64'(done), 64'd0);
            if (blk == ABC) begin
                if (idx == 16) chk({tag, "_abc_w16"}, 64'(w_out), 64'h61626380);
                if (idx == 17) chk({tag, "_abc_w17"}, 64'(w_out), 64'h000F0000);
                if (idx == 18) chk({tag, "_abc_w18"}, 64'(w_out), 64'h7DA86405);
            end
            rdy = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
            w_ready = rdy;
            if (idx == abort_at) begin
                abort = 1'b1;
                w_ready = 1'b1;
            end
            if (idx == rst_at) RST = 1'b0;
            @(posedge CLK);
            if (idx == abort_at || idx == rst_at) break;
            if (w_ready) begin
                hs++;
                if (idx == 63) break;
                idx++;
            end else begin
                stalls++;
            end
        end
        @(negedge CLK);
        cyc++;
        w_ready = 1'b0;
        abort = 1'b0;
        if (!hold_next) in_valid = 1'b0;
        if (timed_out) begin
            chk({tag, "_timeout_end"}, 64'd0, 64'd1);
        end else if (idx == abort_at) begin
            chk({tag, "_abort_valid"}, 64'(w_valid), 64'd0);
            chk({tag, "_abort_done"}, 64'(done), 64'd0);
            chk({tag, "_abort_ready"}, 64'(in_ready), 64'd1);
            chk({tag, "_abort_idx"}, 64'(w_idx), 64'd0);
            @(negedge CLK);
            chk({tag, "_abort_nodone"}, 64'(done), 64'd0);
        end else if (idx == rst_at) begin
            RST = 1'b1;
            chk({tag, "_rst_outs"}, {w_valid, w_last, done, busy, in_ready, w_idx, w_out},
                {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 32'd0});
            @(negedge CLK);
            chk({tag, "_rst_nodone"}, 64'(done), 64'd0);
        end else begin
            chk({tag, "_done"}, 64'(done), 64'd1);
            chk({tag, "_done_valid"}, 64'(w_valid), 64'd0);
            chk({tag, "_done_ready"}, 64'(in_ready), 64'd1);
            chk({tag, "_handshakes"}, 64'(hs), 64'd64);
            if (rdy_pct >= 100) chk({tag, "_done_cycle"}, 64'(cyc), 64'd65);
`ifdef SHA256_WSCHED_STALL_CNT_EN
            chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(stalls));
`endif
            if (!hold_next) begin
                @(negedge CLK);
                chk({tag, "_done_pulse"}, 64'(done), 64'd0);
            end
        end
    endtask

    initial begin
        logic [511:0] rb;
        logic [511:0] rb2;
        RST = 1'b0;
        in_valid = 1'b1;
        block_in = ABC;
        abort = 1'b0;
        w_ready = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        in_valid = 1'b0;
        chk("reset_outs", {w_valid, w_last, done, busy, in_ready, w_idx, w_out},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 32'd0});

        run_block("abc_full", ABC, 100, -1, -1, 0, '0, 0);
        run_block("abc_stall", ABC, 50, -1, -1, 0, '0, 0);
        run_block("abort20", ABC, 100, 20, -1, 0, '0, 0);
        rb = {16{$urandom()}};
        for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom();
        run_block("after_abort", rb, 100, -1, -1, 0, '0, 0);
        for (int i = 0; i < 16; i++) rb2[32*i +: 32] = $urandom();
        run_block("b2b_first", ABC, 70, -1, -1, 1, rb2, 0);
        run_block("b2b_second", rb2, 70, -1, -1, 0, '0, 1);
        run_block("rst40", rb, 100, -1, 40, 0, '0, 0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom();
            run_block("rand", rb, 50, -1, -1, 0, '0, 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
